// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand forwarding and load-use hazard control for the 5-stage pipeline.
// WB needs no slot: the regfile writes before it reads.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_alt_a,
  input  logic                  id_alt_b,
  input  logic                  id_wr_en,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_is_load,
  input  logic                  id_flush,
  input  logic                  mem_ready,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      fwd_cnt
);

  typedef enum logic [1:0] {StRun, StLu, StFrz} state_e;

  state_e state_q, state_d, ret_q, ret_d;

  logic                  ex_valid_q, ex_wr_q, ex_load_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  logic                  mem_valid_q, mem_wr_q;
  logic [REG_ADDR_W-1:0] mem_rd_q;

  logic [1:0]       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W:0]   stall_sum, fwd_sum;
  logic [1:0]       fwd_inc;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, lu;

  // Register $0 is hard-wired, so it never matches a producer.
  assign ex_hit_a  = ex_valid_q & ex_wr_q & (ex_rd_q == id_rs) & (id_rs != '0);
  assign ex_hit_b  = ex_valid_q & ex_wr_q & (ex_rd_q == id_rt) & (id_rt != '0);
  assign mem_hit_a = mem_valid_q & mem_wr_q & (mem_rd_q == id_rs) & (id_rs != '0);
  assign mem_hit_b = mem_valid_q & mem_wr_q & (mem_rd_q == id_rt) & (id_rt != '0);

  assign lu = id_valid & ~id_flush & ex_load_q &
              ((id_uses_rs & ex_hit_a) | (id_uses_rt & ex_hit_b));

  function automatic logic [1:0] pick(input logic alt, input logic uses,
                                      input logic ex_hit, input logic mem_hit);
    if (alt) begin
      return 2'b11;
    end else if (!uses) begin
      return 2'b00;
    end else if (ex_hit) begin
      return 2'b01;
    end else if (mem_hit) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  always_comb begin
    stall_if_id = lu | ~mem_ready;
    bubble_ex   = (lu | id_flush | ~id_valid) & mem_ready;

    sel_a_d = bubble_ex ? 2'b00 : pick(id_alt_a, id_uses_rs, ex_hit_a, mem_hit_a);
    sel_b_d = bubble_ex ? 2'b00 : pick(id_alt_b, id_uses_rt, ex_hit_b, mem_hit_b);

    // 01 and 10 are exactly the selects with odd parity.
    fwd_inc   = {1'b0, ^sel_a_d} + {1'b0, ^sel_b_d};
    fwd_sum   = {1'b0, fwd_cnt_q} + (CNT_W+1)'(fwd_inc);
    fwd_cnt_d = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];

    stall_sum   = {1'b0, stall_cnt_q} + (CNT_W+1)'(lu);
    stall_cnt_d = stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    case (state_q)
      StRun: begin
        if (!mem_ready) begin
          state_d = StFrz;
          ret_d   = StRun;
        end else if (lu) begin
          state_d = StLu;
        end
      end
      StLu: begin
        if (!mem_ready) begin
          state_d = StFrz;
          ret_d   = StLu;
        end else begin
          state_d = StRun;
        end
      end
      StFrz: begin
        if (mem_ready) state_d = ret_q;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      ret_q       <= StRun;
      ex_valid_q  <= 1'b0;
      ex_wr_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_rd_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= '0;
      sel_a_q     <= 2'b00;
      sel_b_q     <= 2'b00;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      if (mem_ready) begin
        mem_valid_q <= ex_valid_q;
        mem_wr_q    <= ex_wr_q;
        mem_rd_q    <= ex_rd_q;
        ex_valid_q  <= ~bubble_ex;
        ex_wr_q     <= id_wr_en & ~bubble_ex;
        ex_load_q   <= id_is_load & ~bubble_ex;
        ex_rd_q     <= id_rd;
        sel_a_q     <= sel_a_d;
        sel_b_q     <= sel_b_d;
        stall_cnt_q <= stall_cnt_d;
        fwd_cnt_q   <= fwd_cnt_d;
      end
    end
  end

  assign fwd_a_sel = sel_a_q;
  assign fwd_b_sel = sel_b_q;
  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomized and directed bench for fwd_hazard_ctrl, checked against a history-queue model.
// A second instance with 3-bit counters exercises saturation.
module tb_fwd_hazard_ctrl;

  localparam int AW  = 5;
  localparam int BIG = 16;
  localparam int SML = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 0, id_uses_rs = 0, id_uses_rt = 0, id_alt_a = 0, id_alt_b = 0;
  logic id_wr_en = 0, id_is_load = 0, id_flush = 0, mem_ready = 1;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;

  logic [1:0]     fwd_a_sel, fwd_b_sel, s_fa, s_fb;
  logic           stall_if_id, bubble_ex, s_stall, s_bub;
  logic [BIG-1:0] stall_cnt, fwd_cnt;
  logic [SML-1:0] s_scnt, s_fcnt;

  fwd_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_alt_a(id_alt_a),
    .id_alt_b(id_alt_b), .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load),
    .id_flush(id_flush), .mem_ready(mem_ready), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
    .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  fwd_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(SML)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_alt_a(id_alt_a),
    .id_alt_b(id_alt_b), .id_wr_en(id_wr_en), .id_rd(id_rd), .id_is_load(id_is_load),
    .id_flush(id_flush), .mem_ready(mem_ready), .fwd_a_sel(s_fa),
    .fwd_b_sel(s_fb), .stall_if_id(s_stall), .bubble_ex(s_bub),
    .stall_cnt(s_scnt), .fwd_cnt(s_fcnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: issued-instruction history, newest first (index 0 = EX, 1 = MEM).
  typedef struct packed {bit v; bit w; bit [AW-1:0] rd; bit ld;} slot_t;
  slot_t hist[$];
  int m_sa = 0, m_sb = 0, m_stall = 0, m_fwd = 0;

  function automatic int sat(input int n, input int w);
    int top = (1 << w) - 1;
    return (n > top) ? top : n;
  endfunction

  function automatic bit writes(input int k, input bit [AW-1:0] s);
    return (s != 0) && hist[k].v && hist[k].w && (hist[k].rd == s);
  endfunction

  function automatic int src_sel(input bit alt, input bit uses, input bit [AW-1:0] s);
    if (alt) return 3;
    if (!uses) return 0;
    for (int k = 0; k < hist.size(); k++) if (writes(k, s)) return k + 1;
    return 0;
  endfunction

  function automatic bit model_lu();
    return id_valid && !id_flush && hist[0].ld &&
           ((id_uses_rs && writes(0, id_rs)) || (id_uses_rt && writes(0, id_rt)));
  endfunction

  task automatic model_reset();
    slot_t z;
    z = '0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    m_sa = 0; m_sb = 0; m_stall = 0; m_fwd = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin : b_cmp
    bit lu, bub;
    int sa, sb;
    slot_t n;
    if (chk_en) begin
      lu  = model_lu();
      bub = (lu || id_flush || !id_valid) && mem_ready;
      chk("stall_if_id", int'(stall_if_id), int'(lu || !mem_ready));
      chk("bubble_ex", int'(bubble_ex), int'(bub));
      chk("fwd_a_sel", int'(fwd_a_sel), m_sa);
      chk("fwd_b_sel", int'(fwd_b_sel), m_sb);
      chk("stall_cnt", int'(stall_cnt), sat(m_stall, BIG));
      chk("fwd_cnt", int'(fwd_cnt), sat(m_fwd, BIG));
      chk("small fwd_a_sel", int'(s_fa), m_sa);
      chk("small stall_cnt", int'(s_scnt), sat(m_stall, SML));
      chk("small fwd_cnt", int'(s_fcnt), sat(m_fwd, SML));
      if (rst) begin
        model_reset();
      end else if (mem_ready) begin
        sa = bub ? 0 : src_sel(id_alt_a, id_uses_rs, id_rs);
        sb = bub ? 0 : src_sel(id_alt_b, id_uses_rt, id_rt);
        m_fwd   += int'(sa == 1 || sa == 2) + int'(sb == 1 || sb == 2);
        m_stall += int'(lu);
        n = '0;
        if (!bub) begin
          n.v = 1; n.w = id_wr_en; n.rd = id_rd; n.ld = id_is_load;
        end
        hist.push_front(n);
        void'(hist.pop_back());
        m_sa = sa;
        m_sb = sb;
      end
    end
  end

  task automatic drive(input bit v, input bit [AW-1:0] rs, input bit urs,
                       input bit [AW-1:0] rt, input bit urt, input bit wr,
                       input bit [AW-1:0] rd, input bit ld, input bit fl, input bit mr,
                       input bit aa, input bit ab);
    @(posedge clk);
    #1;
    rst = 0; id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    id_wr_en = wr; id_rd = rd; id_is_load = ld; id_flush = fl; mem_ready = mr;
    id_alt_a = aa; id_alt_b = ab;
    #1;
  endtask

  task automatic instr(input bit [AW-1:0] rs, input bit urs, input bit [AW-1:0] rt,
                       input bit urt, input bit wr, input bit [AW-1:0] rd, input bit ld);
    drive(1, rs, urs, rt, urt, wr, rd, ld, 0, 1, 0, 0);
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic do_reset();
    nop();
    rst = 1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1;

    // 1: back-to-back EX forward
    do_reset();
    instr(1, 1, 2, 1, 1, 3, 0);
    instr(3, 1, 1, 1, 1, 4, 0);
    nop();
    chk("t1 fwd_a", int'(fwd_a_sel), 1);
    chk("t1 fwd_b", int'(fwd_b_sel), 0);
    chk("t1 fwd_cnt", int'(fwd_cnt), 1);

    // 2: MEM forward, then newer write wins
    do_reset();
    instr(0, 0, 0, 0, 1, 5, 0);
    instr(7, 1, 8, 1, 1, 6, 0);
    instr(0, 0, 5, 1, 0, 0, 0);
    nop();
    chk("t2 fwd_b mem", int'(fwd_b_sel), 2);
    instr(0, 0, 0, 0, 1, 5, 0);
    instr(0, 0, 0, 0, 1, 5, 0);
    instr(0, 0, 5, 1, 0, 0, 0);
    nop();
    chk("t2 fwd_b newest", int'(fwd_b_sel), 1);

    // 3: load-use
    do_reset();
    instr(0, 0, 0, 0, 1, 2, 1);
    instr(2, 1, 9, 1, 1, 10, 0);
    chk("t3 stall", int'(stall_if_id), 1);
    chk("t3 bubble", int'(bubble_ex), 1);
    instr(2, 1, 9, 1, 1, 10, 0);
    chk("t3 stall released", int'(stall_if_id), 0);
    chk("t3 bubble released", int'(bubble_ex), 0);
    chk("t3 bubble sel", int'(fwd_a_sel), 0);
    nop();
    chk("t3 fwd_a", int'(fwd_a_sel), 2);
    chk("t3 stall_cnt", int'(stall_cnt), 1);

    // 4: $0 never forwards; alt overrides hazard
    do_reset();
    instr(0, 0, 0, 0, 1, 0, 0);
    instr(0, 1, 0, 1, 1, 8, 0);
    chk("t4 no stall", int'(stall_if_id), 0);
    instr(0, 0, 0, 0, 1, 7, 0);
    chk("t4 r0 a", int'(fwd_a_sel), 0);
    chk("t4 r0 b", int'(fwd_b_sel), 0);
    drive(1, 7, 1, 7, 1, 0, 0, 0, 0, 1, 0, 1);
    nop();
    chk("t4 alt b", int'(fwd_b_sel), 3);
    chk("t4 fwd a", int'(fwd_a_sel), 1);

    // 5a: flush beats load-use
    do_reset();
    instr(0, 0, 0, 0, 1, 2, 1);
    drive(1, 2, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    chk("t5 flush stall", int'(stall_if_id), 0);
    chk("t5 flush bubble", int'(bubble_ex), 1);
    nop();
    chk("t5 flush stall_cnt", int'(stall_cnt), 0);

    // 5b: freeze during load-use
    do_reset();
    instr(0, 0, 0, 0, 1, 3, 0);
    instr(3, 1, 0, 0, 1, 2, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("t5 frz stall", int'(stall_if_id), 1);
      chk("t5 frz bubble", int'(bubble_ex), 0);
      chk("t5 frz fwd_a hold", int'(fwd_a_sel), 1);
      chk("t5 frz fwd_cnt hold", int'(fwd_cnt), 1);
    end
    drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("t5 lu resume stall", int'(stall_if_id), 1);
    chk("t5 lu resume bubble", int'(bubble_ex), 1);
    instr(2, 1, 0, 0, 0, 0, 0);
    chk("t5 lu done", int'(stall_if_id), 0);
    chk("t5 stall_cnt", int'(stall_cnt), 1);
    nop();
    chk("t5 fwd_a mem", int'(fwd_a_sel), 2);

    // 6: reset mid load-use
    do_reset();
    instr(0, 0, 0, 0, 1, 2, 1);
    instr(0, 0, 0, 0, 1, 4, 1);
    instr(4, 1, 2, 1, 0, 0, 0);
    chk("t6 lu before rst", int'(stall_if_id), 1);
    rst = 1;
    instr(4, 1, 2, 1, 0, 0, 0);
    chk("t6 stall", int'(stall_if_id), 0);
    chk("t6 bubble", int'(bubble_ex), 0);
    chk("t6 fwd_a", int'(fwd_a_sel), 0);
    chk("t6 fwd_b", int'(fwd_b_sel), 0);
    chk("t6 stall_cnt", int'(stall_cnt), 0);
    nop();
    chk("t6 no stale fwd_a", int'(fwd_a_sel), 0);
    chk("t6 no stale fwd_b", int'(fwd_b_sel), 0);

    // Saturation: 9 load-use pairs against 3-bit counters
    do_reset();
    repeat (9) begin
      instr(0, 0, 0, 0, 1, 2, 1);
      instr(2, 1, 0, 0, 0, 0, 0);
      instr(2, 1, 0, 0, 0, 0, 0);
    end
    nop();
    chk("sat big stall_cnt", int'(stall_cnt), 9);
    chk("sat big fwd_cnt", int'(fwd_cnt), 9);
    chk("sat small stall_cnt", int'(s_scnt), 7);
    chk("sat small fwd_cnt", int'(s_fcnt), 7);

    // Random phase
    do_reset();
    repeat (3000) begin
      drive($urandom_range(0, 99) < 85, AW'($urandom_range(0, 3)), 1'($urandom),
            AW'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 99) < 70,
            AW'($urandom_range(0, 3)), $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 80,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15);
      if ($urandom_range(0, 199) == 0) rst = 1;
    end
    nop();
    nop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
